// File: rtl/brinquedo_controle.sv
// brinquedo_controle: main sequencing controller for the automatic toy.
// Synchronises the buttons and sensors, debounces the buttons, and runs a
// Moore state machine with tick-timed states driving the motors. The state
// code on bit2..bit0 feeds the 7-segment decoder directly.
module brinquedo_controle #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned T_START    = 2,
  parameter int unsigned T_RUN_MAX  = 30,
  parameter int unsigned T_BACK     = 3,
  parameter int unsigned T_TURN     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_n,
  input  logic btn_stop_n,
  input  logic sens_obst,
  input  logic sens_side,
  output logic bit2,
  output logic bit1,
  output logic bit0,
  output logic motor_l,
  output logic motor_r,
  output logic motor_dir
);

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TM01 = (T_START > T_RUN_MAX) ? T_START : T_RUN_MAX;
  localparam int unsigned TM23 = (T_BACK > T_TURN) ? T_BACK : T_TURN;
  localparam int unsigned TMAX = (TM01 > TM23) ? TM01 : TM23;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    StIdle      = 3'b000,
    StStarting  = 3'b001,
    StForward   = 3'b010,
    StTurnLeft  = 3'b011,
    StTurnRight = 3'b100,
    StBackward  = 3'b101,
    StPaused    = 3'b110,
    StError     = 3'b111
  } state_e;

  state_e state_q, state_d;

  // Bit order: 0 = start_n, 1 = stop_n, 2 = obstacle, 3 = side.
  logic [3:0] sync1_q, sync2_q;

  logic [1:0]    lvl_q;    // accepted button level, 1 = released
  logic [1:0]    armed_q;  // set once the pin has been seen released
  logic [1:0]    press_q;  // one-cycle press pulses
  logic [DW-1:0] cnt_q [2];

  logic [PW-1:0] presc_q;
  logic [TW-1:0] tcnt_q;

  logic start_p, stop_p, obst, side, tick;
  logic exp_start, exp_run, exp_back, exp_turn;

  assign start_p = press_q[0];
  assign stop_p  = press_q[1];
  assign obst    = sync2_q[2];
  assign side    = sync2_q[3];

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign exp_start = tick && (tcnt_q == TW'(T_START - 1));
  assign exp_run   = tick && (tcnt_q == TW'(T_RUN_MAX - 1));
  assign exp_back  = tick && (tcnt_q == TW'(T_BACK - 1));
  assign exp_turn  = tick && (tcnt_q == TW'(T_TURN - 1));

  // Two-flop synchroniser. Resetting to 0 makes a button held through reset
  // look pressed, so it cannot arm until it is actually released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {sens_side, sens_obst, btn_stop_n, btn_start_n};
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce and released-to-pressed pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= 2'b11;
      armed_q <= 2'b00;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i]) armed_q[i] <= 1'b1;
        if (sync2_q[i] != lvl_q[i]) begin
          if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            lvl_q[i]   <= sync2_q[i];
            cnt_q[i]   <= '0;
            // lvl_q = 1 here means the new level is pressed
            press_q[i] <= lvl_q[i] & armed_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Prescaler and tick timer, cleared on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tcnt_q  <= '0;
    end else if (state_d != state_q) begin
      presc_q <= '0;
      tcnt_q  <= '0;
    end else if (tick) begin
      presc_q <= '0;
      tcnt_q  <= tcnt_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop beats start beats obstacle beats timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!stop_p && start_p) state_d = StStarting;
      end
      StStarting: begin
        if (stop_p)         state_d = StIdle;
        else if (exp_start) state_d = StForward;
      end
      StForward: begin
        if (stop_p)       state_d = StPaused;
        else if (start_p) state_d = StForward;
        else if (obst)    state_d = StBackward;
        else if (exp_run) state_d = StIdle;
      end
      StTurnLeft, StTurnRight: begin
        if (stop_p)        state_d = StPaused;
        else if (exp_turn) state_d = StForward;
      end
      StBackward: begin
        if (stop_p) begin
          state_d = StPaused;
        end else if (exp_back) begin
          if (obst)      state_d = StError;
          else if (side) state_d = StTurnRight;
          else           state_d = StTurnLeft;
        end
      end
      StPaused: begin
        if (stop_p)       state_d = StIdle;
        else if (start_p) state_d = StForward;
      end
      StError: begin
        if (stop_p) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode of the state register.
  always_comb begin
    {bit2, bit1, bit0} = state_q;
    motor_l   = 1'b0;
    motor_r   = 1'b0;
    motor_dir = 1'b0;
    case (state_q)
      StForward: begin
        motor_l   = 1'b1;
        motor_r   = 1'b1;
        motor_dir = 1'b1;
      end
      StBackward: begin
        motor_l = 1'b1;
        motor_r = 1'b1;
      end
      StTurnLeft: begin
        motor_r   = 1'b1;
        motor_dir = 1'b1;
      end
      StTurnRight: begin
        motor_l   = 1'b1;
        motor_dir = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
